// File: rtl/snn_interfaces_pkg.sv
// rtl/snn_interfaces_pkg.sv - shared types, client indices and address helper for the fmap arbiter
//
// Purpose: arbiter state encoding, default feature-map geometry, client index
// constants and the (x, y) -> linear address translation.
// Ports: none (package).
// Configuration macro: FMAP_ARB_BYPASS_EN (consumed by fmap_mem_arbiter).
package snn_interfaces_pkg;

   localparam int DEFAULT_CHANNELS    = 2;
   localparam int DEFAULT_NEURON_BITS = 8;
   localparam int DEFAULT_IMG_WIDTH   = 8;
   localparam int DEFAULT_IMG_HEIGHT  = 8;

   localparam int CLIENT_CONV = 0;
   localparam int CLIENT_POOL = 1;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_OWN0  = 2'd1,
      ARB_OWN1  = 2'd2,
      ARB_DRAIN = 2'd3
   } arb_state_t;

   // Row-major layout: consecutive x within a row are adjacent words.
   function automatic int unsigned coord_to_addr(input int unsigned x,
                                                 input int unsigned y,
                                                 input int unsigned width);
      return y * width + x;
   endfunction

endpackage

// File: rtl/fmap_arb_fsm.sv
// rtl/fmap_arb_fsm.sv - ownership state machine with round-robin tie break
//
// Purpose: holds the arbiter state and last owner, decodes per-client grants.
// Ports:
//   clk      in   clock
//   reset    in   synchronous, active-low reset
//   own_req  in   [1:0] per-client ownership request
//   state    out  current arbiter state
//   own_gnt  out  [1:0] one-hot or zero grant, decoded from state
module fmap_arb_fsm
   import snn_interfaces_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] own_req,
   output arb_state_t state,
   output logic [1:0] own_gnt
);

   arb_state_t state_q, state_d;
   logic       last_owner_q, last_owner_d;

   // Selection used from IDLE and DRAIN: a sole requester wins, a tie goes
   // to the client that did not own the memory last.
   function automatic arb_state_t select_owner(input logic [1:0] req,
                                               input logic       last);
      arb_state_t nxt;
      case (req)
         2'b01:   nxt = ARB_OWN0;
         2'b10:   nxt = ARB_OWN1;
         2'b11:   nxt = last ? ARB_OWN0 : ARB_OWN1;
         default: nxt = ARB_IDLE;
      endcase
      return nxt;
   endfunction

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      case (state_q)
         ARB_IDLE, ARB_DRAIN: state_d = select_owner(own_req, last_owner_q);
         ARB_OWN0:            state_d = own_req[CLIENT_CONV] ? ARB_OWN0 : ARB_DRAIN;
         ARB_OWN1:            state_d = own_req[CLIENT_POOL] ? ARB_OWN1 : ARB_DRAIN;
         default:             state_d = ARB_IDLE;
      endcase
      if (state_d == ARB_OWN0 && state_q != ARB_OWN0) last_owner_d = 1'b0;
      if (state_d == ARB_OWN1 && state_q != ARB_OWN1) last_owner_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ARB_IDLE;
         last_owner_q <= 1'b1;   // client 0 wins the first tie
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
      end
   end

   assign state   = state_q;
   assign own_gnt = {state_q == ARB_OWN1, state_q == ARB_OWN0};

endmodule

// File: rtl/fmap_mem_arbiter.sv
// rtl/fmap_mem_arbiter.sv - shares one 1R/1W feature-map memory between conv and pool engines
//
// Purpose: exclusive round-robin ownership of the memory, coordinate to
// address translation, range checking and read-data return to the owner.
// Ports:
//   clk, reset                     clock, synchronous active-low reset
//   own_req / own_gnt              ownership handshake per client
//   rd_req, rd_x, rd_y             per-client read strobe and coordinate
//   rd_data, rd_valid              shared read data, per-client valid (1 cycle later)
//   wr_req, wr_x, wr_y, wr_data    per-client write strobe, coordinate, data
//   mem_rd_*, mem_wr_*             memory ports (read data 1 cycle after mem_rd_en)
//   addr_err                       sticky out-of-range coordinate flag
//   busy                           arbiter not idle
// Configuration macro: FMAP_ARB_BYPASS_EN - same-address read/write in one
// cycle returns the new write data; otherwise the old memory contents.
module fmap_mem_arbiter
   import snn_interfaces_pkg::*;
#(
   parameter int CHANNELS         = DEFAULT_CHANNELS,
   parameter int BITS_PER_CHANNEL = DEFAULT_NEURON_BITS,
   parameter int IMG_WIDTH        = DEFAULT_IMG_WIDTH,
   parameter int IMG_HEIGHT       = DEFAULT_IMG_HEIGHT,
   localparam int XW = $clog2(IMG_WIDTH),
   localparam int YW = $clog2(IMG_HEIGHT),
   localparam int DW = CHANNELS * BITS_PER_CHANNEL,
   localparam int AW = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            own_req,
   output logic [1:0]            own_gnt,
   input  logic [1:0]            rd_req,
   input  logic [1:0][XW-1:0]    rd_x,
   input  logic [1:0][YW-1:0]    rd_y,
   output logic [DW-1:0]         rd_data,
   output logic [1:0]            rd_valid,
   input  logic [1:0]            wr_req,
   input  logic [1:0][XW-1:0]    wr_x,
   input  logic [1:0][YW-1:0]    wr_y,
   input  logic [1:0][DW-1:0]    wr_data,
   output logic                  mem_rd_en,
   output logic [AW-1:0]         mem_rd_addr,
   input  logic [DW-1:0]         mem_rd_data,
   output logic                  mem_wr_en,
   output logic [AW-1:0]         mem_wr_addr,
   output logic [DW-1:0]         mem_wr_data,
   output logic                  addr_err,
   output logic                  busy
);

   localparam int unsigned W_U = IMG_WIDTH;
   localparam int unsigned H_U = IMG_HEIGHT;

   arb_state_t state;
   logic       owned;
   logic       sel;
   logic       rd_hit, wr_hit, rd_in, wr_in, rd_ok, wr_ok;
   logic [1:0] rd_valid_q, rd_valid_d;
   logic       addr_err_q, addr_err_d;

   fmap_arb_fsm u_fsm (
      .clk     (clk),
      .reset   (reset),
      .own_req (own_req),
      .state   (state),
      .own_gnt (own_gnt)
   );

   always_comb begin
      owned       = |own_gnt;
      sel         = own_gnt[CLIENT_POOL];
      // Only the current owner's strobes are looked at; the other client is
      // silently ignored, and nothing reaches memory in IDLE or DRAIN.
      rd_hit      = owned & rd_req[sel];
      wr_hit      = owned & wr_req[sel];
      rd_in       = (32'(rd_x[sel]) < W_U) && (32'(rd_y[sel]) < H_U);
      wr_in       = (32'(wr_x[sel]) < W_U) && (32'(wr_y[sel]) < H_U);
      rd_ok       = rd_hit & rd_in;
      wr_ok       = wr_hit & wr_in;
      mem_rd_addr = AW'(coord_to_addr(32'(rd_x[sel]), 32'(rd_y[sel]), W_U));
      mem_wr_addr = AW'(coord_to_addr(32'(wr_x[sel]), 32'(wr_y[sel]), W_U));
      mem_wr_data = wr_data[sel];
      // Enables are held low while reset is asserted even if a grant is
      // still showing from before the reset edge.
      mem_rd_en   = reset & rd_ok;
      mem_wr_en   = reset & wr_ok;
      rd_valid_d  = 2'b00;
      if (rd_ok) rd_valid_d[sel] = 1'b1;
      addr_err_d  = addr_err_q | (rd_hit & ~rd_in) | (wr_hit & ~wr_in);
   end

`ifdef FMAP_ARB_BYPASS_EN
   logic          byp_hit_q, byp_hit_d;
   logic [DW-1:0] byp_data_q, byp_data_d;

   always_comb begin
      byp_hit_d  = rd_ok & wr_ok & (mem_rd_addr == mem_wr_addr);
      byp_data_d = wr_data[sel];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         byp_hit_q  <= 1'b0;
         byp_data_q <= '0;
      end else begin
         byp_hit_q  <= byp_hit_d;
         byp_data_q <= byp_data_d;
      end
   end

   assign rd_data = (|rd_valid_q) ? (byp_hit_q ? byp_data_q : mem_rd_data) : '0;
`else
   assign rd_data = (|rd_valid_q) ? mem_rd_data : '0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_valid_q <= 2'b00;   // drops any read in flight
         addr_err_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_valid_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign addr_err = addr_err_q;
   assign busy     = (state != ARB_IDLE);

endmodule

// File: tb/tb_fmap_mem_arbiter.sv
// tb/tb_fmap_mem_arbiter.sv - directed self-checking bench for fmap_mem_arbiter
module tb_fmap_mem_arbiter;

   localparam int CH = 2;
   localparam int BPC = 8;
   localparam int W = 8;
   localparam int H = 6;
   localparam int XW = 3;
   localparam int YW = 3;
   localparam int DW = 16;
   localparam int AW = 6;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [1:0]           own_req;
   logic [1:0]           own_gnt;
   logic [1:0]           rd_req;
   logic [1:0][XW-1:0]   rd_x;
   logic [1:0][YW-1:0]   rd_y;
   logic [DW-1:0]        rd_data;
   logic [1:0]           rd_valid;
   logic [1:0]           wr_req;
   logic [1:0][XW-1:0]   wr_x;
   logic [1:0][YW-1:0]   wr_y;
   logic [1:0][DW-1:0]   wr_data;
   logic                 mem_rd_en;
   logic [AW-1:0]        mem_rd_addr;
   logic [DW-1:0]        mem_rd_data;
   logic                 mem_wr_en;
   logic [AW-1:0]        mem_wr_addr;
   logic [DW-1:0]        mem_wr_data;
   logic                 addr_err;
   logic                 busy;

   logic [DW-1:0] mem [0:63];
   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   fmap_mem_arbiter #(
      .CHANNELS(CH), .BITS_PER_CHANNEL(BPC), .IMG_WIDTH(W), .IMG_HEIGHT(H)
   ) dut (
      .clk(clk), .reset(reset), .own_req(own_req), .own_gnt(own_gnt),
      .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
      .rd_valid(rd_valid), .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y),
      .wr_data(wr_data), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .addr_err(addr_err), .busy(busy)
   );

   // 1R/1W memory, 1-cycle read latency, read-first on address collision.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
      if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
      mem_rd_data = '0;
      reset = 1'b0;
      own_req = 2'b00; rd_req = 2'b00; wr_req = 2'b00;
      rd_x = '0; rd_y = '0; wr_x = '0; wr_y = '0; wr_data = '0;
      tick(); tick();
      check("rst_gnt", 32'(own_gnt), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_valid", 32'(rd_valid), 32'h0);
      check("rst_err", 32'(addr_err), 32'h0);
      check("rst_rden", 32'(mem_rd_en), 32'h0);

      // release reset with both clients requesting: client 0 wins first tie
      reset = 1'b1; own_req = 2'b11;
      tick();
      check("tie0_gnt", 32'(own_gnt), 32'h1);
      check("tie0_busy", 32'(busy), 32'h1);

      // client 0 reads (3,2) -> 2*8+3 = 19
      rd_req = 2'b01; rd_x[0] = 3'd3; rd_y[0] = 3'd2;
      #1;
      check("rd19_en", 32'(mem_rd_en), 32'h1);
      check("rd19_addr", 32'(mem_rd_addr), 32'd19);
      // back-to-back read of (0,0)
      tick();
      rd_x[0] = 3'd0; rd_y[0] = 3'd0;
      check("rd19_valid", 32'(rd_valid), 32'h1);
      check("rd19_data", 32'(rd_data), 32'hA013);
      tick();
      check("rd0_valid", 32'(rd_valid), 32'h1);
      check("rd0_data", 32'(rd_data), 32'hA000);

      // client 1 write during OWN0 is ignored
      rd_req = 2'b00; wr_req = 2'b10; wr_x[1] = 3'd1; wr_y[1] = 3'd0; wr_data[1] = 16'h5555;
      #1;
      check("nonown1_wren", 32'(mem_wr_en), 32'h0);

      // last OWN0 cycle: drop own_req[0] and issue a final read of (4,0)
      wr_req = 2'b00; own_req = 2'b10;
      rd_req = 2'b01; rd_x[0] = 3'd4; rd_y[0] = 3'd0;
      tick();
      rd_req = 2'b00;
      check("drain_gnt", 32'(own_gnt), 32'h0);
      check("drain_busy", 32'(busy), 32'h1);
      check("drain_valid", 32'(rd_valid), 32'h1);
      check("drain_data", 32'(rd_data), 32'hA004);
      tick();
      check("own1_gnt", 32'(own_gnt), 32'h2);

      // client 0 write during OWN1 must not reach memory
      wr_req = 2'b01; wr_x[0] = 3'd1; wr_y[0] = 3'd1; wr_data[0] = 16'hBEEF;
      #1;
      check("nonown0_wren", 32'(mem_wr_en), 32'h0);
      tick();
      check("nonown0_mem", 32'(mem[9]), 32'hA009);
      check("nonown0_err", 32'(addr_err), 32'h0);

      // client 1 write to (2,1) -> 10
      wr_req = 2'b10; wr_x[1] = 3'd2; wr_y[1] = 3'd1; wr_data[1] = 16'h1234;
      #1;
      check("wr10_en", 32'(mem_wr_en), 32'h1);
      check("wr10_addr", 32'(mem_wr_addr), 32'd10);
      check("wr10_data", 32'(mem_wr_data), 32'h1234);
      tick();
      check("wr10_mem", 32'(mem[10]), 32'h1234);

      // same-cycle read and write to address 5: old A005, new B0B0
      rd_req = 2'b10; rd_x[1] = 3'd5; rd_y[1] = 3'd0;
      wr_req = 2'b10; wr_x[1] = 3'd5; wr_y[1] = 3'd0; wr_data[1] = 16'hB0B0;
      #1;
      check("rw5_rden", 32'(mem_rd_en), 32'h1);
      check("rw5_wren", 32'(mem_wr_en), 32'h1);
      tick();
      rd_req = 2'b00; wr_req = 2'b00;
      check("rw5_valid", 32'(rd_valid), 32'h2);
`ifdef FMAP_ARB_BYPASS_EN
      check("rw5_data", 32'(rd_data), 32'hB0B0);
`else
      check("rw5_data", 32'(rd_data), 32'hA005);
`endif
      check("rw5_mem", 32'(mem[5]), 32'hB0B0);

      // out-of-range write y = IMG_HEIGHT
      wr_req = 2'b10; wr_x[1] = 3'd0; wr_y[1] = 3'd6;
      #1;
      check("oor_wren", 32'(mem_wr_en), 32'h0);
      tick();
      wr_req = 2'b00;
      check("oor_err", 32'(addr_err), 32'h1);
      // out-of-range read y = 7: no enable, no valid
      rd_req = 2'b10; rd_x[1] = 3'd0; rd_y[1] = 3'd7;
      #1;
      check("oor_rden", 32'(mem_rd_en), 32'h0);
      tick();
      rd_req = 2'b00;
      check("oor_valid", 32'(rd_valid), 32'h0);

      // hand back to client 0; error stays set
      own_req = 2'b01;
      tick();
      check("drain2_gnt", 32'(own_gnt), 32'h0);
      tick();
      check("own0b_gnt", 32'(own_gnt), 32'h1);
      check("err_sticky", 32'(addr_err), 32'h1);

      // release, go idle, then a tie goes to client 1 (last owner was 0)
      own_req = 2'b00;
      tick();
      tick();
      check("idle_busy", 32'(busy), 32'h0);
      own_req = 2'b11;
      tick();
      check("tie1_gnt", 32'(own_gnt), 32'h2);

      // reset asserted while client 1 reads
      rd_req = 2'b10; rd_x[1] = 3'd1; rd_y[1] = 3'd1;
      #1;
      check("pre_rst_rden", 32'(mem_rd_en), 32'h1);
      reset = 1'b0;
      #1;
      check("rst_force_rden", 32'(mem_rd_en), 32'h0);
      tick();
      check("rst2_gnt", 32'(own_gnt), 32'h0);
      check("rst2_valid", 32'(rd_valid), 32'h0);
      check("rst2_busy", 32'(busy), 32'h0);
      check("rst2_err", 32'(addr_err), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
